rs_station: RTL and testbench

RS_STATION -- requirements
Module: rs_station

---
 rtl/rs_station.sv | 142 ++++++++++++++
 tb/tb_rs_station.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_station.sv
// Reservation station: holds dispatched ops until both operands are available,
// captures CDB results, and issues the lowest-index ready entry once per cycle.
module rs_station #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned RS_BIT  = 3,
    parameter int unsigned ROB_BIT = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_in,
    input  logic               in_valid,
    input  logic [5:0]         in_op,
    input  logic [31:0]        in_vj,
    input  logic [31:0]        in_vk,
    input  logic               in_qj_busy,
    input  logic               in_qk_busy,
    input  logic [ROB_BIT-1:0] in_qj,
    input  logic [ROB_BIT-1:0] in_qk,
    input  logic [ROB_BIT-1:0] in_rob,
    output logic               full_out,
    input  logic               cdb_valid,
    input  logic [ROB_BIT-1:0] cdb_rob,
    input  logic [31:0]        cdb_value,
    output logic               out_valid,
    output logic [5:0]         out_op,
    output logic [31:0]        out_vj,
    output logic [31:0]        out_vk,
    output logic [ROB_BIT-1:0] out_rob
);

    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_qj_busy;
    logic [RS_SIZE-1:0] r_qk_busy;
    logic [5:0]         r_op  [RS_SIZE];
    logic [31:0]        r_vj  [RS_SIZE];
    logic [31:0]        r_vk  [RS_SIZE];
    logic [ROB_BIT-1:0] r_qj  [RS_SIZE];
    logic [ROB_BIT-1:0] r_qk  [RS_SIZE];
    logic [ROB_BIT-1:0] r_rob [RS_SIZE];

    logic [RS_SIZE-1:0] w_ready;
    logic [RS_BIT:0]    w_free_cnt;
    logic [RS_BIT-1:0]  w_alloc_idx;
    logic [RS_BIT-1:0]  w_issue_idx;
    logic               w_has_free;
    logic               w_has_ready;
    logic               w_byp_j;
    logic               w_byp_k;

    assign w_ready = r_busy & ~r_qj_busy & ~r_qk_busy;

    // Both selections look only at registered state, so a slot freed by issue
    // this edge is not visible to allocation until the next one.
    always_comb begin
        w_free_cnt  = '0;
        w_alloc_idx = '0;
        w_has_free  = 1'b0;
        w_issue_idx = '0;
        w_has_ready = 1'b0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!r_busy[i]) begin
                w_free_cnt = w_free_cnt + (RS_BIT+1)'(1);
                if (!w_has_free) begin
                    w_alloc_idx = RS_BIT'(i);
                    w_has_free  = 1'b1;
                end
            end
            if (w_ready[i] && !w_has_ready) begin
                w_issue_idx = RS_BIT'(i);
                w_has_ready = 1'b1;
            end
        end
    end

    // One spare slot of margin: the dispatcher sees full one cycle late.
    assign full_out = (w_free_cnt <= (RS_BIT+1)'(1));

    assign w_byp_j = cdb_valid && in_qj_busy && (cdb_rob == in_qj);
    assign w_byp_k = cdb_valid && in_qk_busy && (cdb_rob == in_qk);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy    <= '0;
            r_qj_busy <= '0;
            r_qk_busy <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                r_op[i]  <= '0;
                r_vj[i]  <= '0;
                r_vk[i]  <= '0;
                r_qj[i]  <= '0;
                r_qk[i]  <= '0;
                r_rob[i] <= '0;
            end
            out_valid <= 1'b0;
            out_op    <= '0;
            out_vj    <= '0;
            out_vk    <= '0;
            out_rob   <= '0;
        end else if (!rdy_in) begin
            out_valid <= 1'b0;
        end else if (clear_in) begin
            r_busy    <= '0;
            out_valid <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (cdb_valid && r_busy[i]) begin
                    if (r_qj_busy[i] && (r_qj[i] == cdb_rob)) begin
                        r_vj[i]      <= cdb_value;
                        r_qj_busy[i] <= 1'b0;
                    end
                    if (r_qk_busy[i] && (r_qk[i] == cdb_rob)) begin
                        r_vk[i]      <= cdb_value;
                        r_qk_busy[i] <= 1'b0;
                    end
                end
            end

            out_valid <= w_has_ready;
            if (w_has_ready) begin
                r_busy[w_issue_idx] <= 1'b0;
                out_op  <= r_op[w_issue_idx];
                out_vj  <= r_vj[w_issue_idx];
                out_vk  <= r_vk[w_issue_idx];
                out_rob <= r_rob[w_issue_idx];
            end

            if (in_valid && w_has_free) begin
                r_busy[w_alloc_idx]    <= 1'b1;
                r_op[w_alloc_idx]      <= in_op;
                r_rob[w_alloc_idx]     <= in_rob;
                r_qj[w_alloc_idx]      <= in_qj;
                r_qk[w_alloc_idx]      <= in_qk;
                r_vj[w_alloc_idx]      <= w_byp_j ? cdb_value : in_vj;
                r_vk[w_alloc_idx]      <= w_byp_k ? cdb_value : in_vk;
                r_qj_busy[w_alloc_idx] <= in_qj_busy && !w_byp_j;
                r_qk_busy[w_alloc_idx] <= in_qk_busy && !w_byp_k;
            end
        end
    end

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: stimulus pushes expected issues (with the
// exact issue cycle) into a queue; a negedge monitor pops and compares.
module tb_rs_station;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_vj, in_vk;
    logic        in_qj_busy, in_qk_busy;
    logic [3:0]  in_qj, in_qk, in_rob;
    logic        full_out;
    logic        cdb_valid;
    logic [3:0]  cdb_rob;
    logic [31:0] cdb_value;
    logic        out_valid;
    logic [5:0]  out_op;
    logic [31:0] out_vj, out_vk;
    logic [3:0]  out_rob;

    rs_station #(.RS_SIZE(8), .RS_BIT(3), .ROB_BIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .in_valid(in_valid), .in_op(in_op), .in_vj(in_vj), .in_vk(in_vk),
        .in_qj_busy(in_qj_busy), .in_qk_busy(in_qk_busy),
        .in_qj(in_qj), .in_qk(in_qk), .in_rob(in_rob), .full_out(full_out),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
        .out_valid(out_valid), .out_op(out_op), .out_vj(out_vj),
        .out_vk(out_vk), .out_rob(out_rob)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [3:0]  rob;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       m_e;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] tagj [8];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_in === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue: got op=0x%0h rob=%0d at cycle %0d, required no issue",
                         out_op, out_rob, cyc);
            end else begin
                m_e = sb.pop_front();
                chk("issue_op",    32'(out_op),  32'(m_e.op));
                chk("issue_vj",    out_vj,       m_e.vj);
                chk("issue_vk",    out_vk,       m_e.vk);
                chk("issue_rob",   32'(out_rob), 32'(m_e.rob));
                chk("issue_cycle", 32'(cyc),     32'(m_e.cyc));
            end
        end
    end

    task automatic idle_in;
        rdy_in     = 1'b1;
        clear_in   = 1'b0;
        in_valid   = 1'b0;
        in_op      = '0;
        in_vj      = '0;
        in_vk      = '0;
        in_qj_busy = 1'b0;
        in_qk_busy = 1'b0;
        in_qj      = '0;
        in_qk      = '0;
        in_rob     = '0;
        cdb_valid  = 1'b0;
        cdb_rob    = '0;
        cdb_value  = '0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic drive_disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                              input logic qjb, input logic [3:0] qj,
                              input logic qkb, input logic [3:0] qk, input logic [3:0] rob);
        in_valid   = 1'b1;
        in_op      = op;
        in_vj      = vj;
        in_vk      = vk;
        in_qj_busy = qjb;
        in_qj      = qj;
        in_qk_busy = qkb;
        in_qk      = qk;
        in_rob     = rob;
    endtask

    task automatic drive_cdb(input logic [3:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1;
        cdb_rob   = tag;
        cdb_value = val;
    endtask

    task automatic expect_issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                input logic [3:0] rob, input int at_cyc);
        exp_t e;
        e.op  = op;
        e.vj  = vj;
        e.vk  = vk;
        e.rob = rob;
        e.cyc = at_cyc;
        sb.push_back(e);
    endtask

    initial begin
        int c;
        tagj = '{4'd8, 4'd9, 4'd10, 4'd12, 4'd11, 4'd12, 4'd13, 4'd14};
        rst_in = 1'b0;
        idle_in();
        step(2);

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_op",    32'(out_op),    32'h0);
        chk("rst_out_vj",    out_vj,         32'h0);
        chk("rst_out_rob",   32'(out_rob),   32'h0);
        chk("rst_full",      32'(full_out),  32'h0);
        rst_in = 1'b1;
        chk("full_after_release", 32'(full_out), 32'h0);
        step(2);

        // Ready dispatch issues one edge after allocation
        c = cyc;
        drive_disp(6'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
        expect_issue(6'd3, 32'd5, 32'd7, 4'd2, c + 2);
        step(1);
        idle_in();
        step(1);
        chk("entry0_freed", 32'(dut.r_busy), 32'h0);
        step(2);

        // CDB wakeup two cycles after dispatch
        drive_disp(6'd1, 32'd0, 32'h10, 1'b1, 4'd4, 1'b0, 4'd0, 4'd5);
        step(1);
        idle_in();
        step(1);
        c = cyc;
        drive_cdb(4'd4, 32'hAA);
        expect_issue(6'd1, 32'hAA, 32'h10, 4'd5, c + 2);
        step(1);
        idle_in();
        step(3);

        // Same-cycle allocate bypass on k
        c = cyc;
        drive_disp(6'd2, 32'h11, 32'd0, 1'b0, 4'd0, 1'b1, 4'd9, 4'd7);
        drive_cdb(4'd9, 32'h55);
        expect_issue(6'd2, 32'h11, 32'h55, 4'd7, c + 2);
        step(1);
        idle_in();
        step(3);

        // One broadcast wakes both operands of an entry
        drive_disp(6'd4, 32'd0, 32'd0, 1'b1, 4'd3, 1'b1, 4'd3, 4'd1);
        step(1);
        idle_in();
        c = cyc;
        drive_cdb(4'd3, 32'h77);
        expect_issue(6'd4, 32'h77, 32'h77, 4'd1, c + 2);
        step(1);
        idle_in();
        step(3);

        // Allocate, wakeup and issue in the same cycle
        c = cyc;
        drive_disp(6'h30, 32'd0, 32'h31, 1'b1, 4'd7, 1'b0, 4'd0, 4'd8);
        step(1);
        idle_in();
        drive_disp(6'h32, 32'h33, 32'h34, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        step(1);
        idle_in();
        drive_disp(6'h35, 32'h36, 32'h37, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
        drive_cdb(4'd7, 32'h70);
        expect_issue(6'h32, 32'h33, 32'h34, 4'd9,  c + 3);
        expect_issue(6'h30, 32'h70, 32'h31, 4'd8,  c + 4);
        expect_issue(6'h35, 32'h36, 32'h37, 4'd10, c + 5);
        step(1);
        idle_in();
        step(4);

        // Fill the station; full_out asserts with one slot still free
        for (int i = 0; i < 8; i++) begin
            idle_in();
            drive_disp(6'(32 + i), 32'd0, 32'(256 + i), 1'b1, tagj[i], 1'b0, 4'd0, 4'(i));
            step(1);
            if (i == 5) chk("full_at_6_busy", 32'(full_out), 32'h0);
            if (i == 6) chk("full_at_7_busy", 32'(full_out), 32'h1);
        end
        idle_in();
        drive_disp(6'h3F, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, 4'hF);
        step(1);
        idle_in();
        step(1);
        chk("all_busy", 32'(dut.r_busy), 32'hFF);
        chk("full_when_full", 32'(full_out), 32'h1);

        c = cyc;
        drive_cdb(4'd12, 32'hC3);
        expect_issue(6'h23, 32'hC3, 32'h103, 4'd3, c + 2);
        expect_issue(6'h25, 32'hC3, 32'h105, 4'd5, c + 3);
        step(1);
        idle_in();
        step(3);
        c = cyc;
        drive_cdb(4'd13, 32'hD6);
        expect_issue(6'h26, 32'hD6, 32'h106, 4'd6, c + 2);
        step(1);
        idle_in();
        drive_cdb(4'd14, 32'hE7);
        expect_issue(6'h27, 32'hE7, 32'h107, 4'd7, c + 3);
        step(1);
        idle_in();
        step(3);
        chk("four_busy", 32'(dut.r_busy), 32'h17);

        // Flush with a ready entry present and a dispatch in the same cycle
        drive_cdb(4'd8, 32'h80);
        step(1);
        idle_in();
        clear_in = 1'b1;
        drive_disp(6'h3E, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, 4'hE);
        step(1);
        chk("clear_busy",      32'(dut.r_busy),  32'h0);
        chk("clear_out_valid", 32'(out_valid),   32'h0);
        chk("clear_full",      32'(full_out),    32'h0);
        idle_in();
        step(3);
        chk("clear_nothing_stored", 32'(dut.r_busy), 32'h0);

        // Pause: no issue, wakeup or allocation while rdy_in is low
        drive_disp(6'h16, 32'h3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd4);
        step(1);
        idle_in();
        drive_disp(6'h15, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        step(1);
        idle_in();
        rdy_in = 1'b0;
        drive_cdb(4'd6, 32'h66);
        drive_disp(6'h3D, 32'h9, 32'h9, 1'b0, 4'd0, 1'b0, 4'd0, 4'hD);
        step(3);
        chk("pause_busy_held", 32'(dut.r_busy), 32'h3);
        idle_in();
        c = cyc;
        expect_issue(6'h15, 32'h1, 32'h2, 4'd3, c + 1);
        step(1);
        c = cyc;
        drive_cdb(4'd6, 32'h99);
        expect_issue(6'h16, 32'h3, 32'h99, 4'd4, c + 2);
        step(1);
        idle_in();
        step(4);

        // Asynchronous reset mid-operation discards a pending issue
        c = cyc;
        drive_disp(6'h01, 32'hA1, 32'hA2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
        expect_issue(6'h01, 32'hA1, 32'hA2, 4'd1, c + 2);
        step(1);
        idle_in();
        drive_disp(6'h02, 32'hB1, 32'hB2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
        step(1);
        idle_in();
        @(negedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'h0);
        chk("async_rst_out_rob",   32'(out_rob),   32'h0);
        chk("async_rst_out_vj",    out_vj,         32'h0);
        chk("async_rst_busy",      32'(dut.r_busy), 32'h0);
        step(2);
        rst_in = 1'b1;
        chk("full_after_rerelease", 32'(full_out), 32'h0);
        step(4);

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
